cacheline_adapter: RTL and testbench
====================================

// Module: cacheline_adapter
// PURPOSE
//  Responder for the cacheline (CLA) request port driven by the I/D-cache arbiter.
//  Converts one 256-bit line read/write into BEATS 64-bit bursts on the banked-memory (bmem) port.
//  Returns the assembled line with its aligned address and a one-cycle response pulse.
//  Supports discard of an in-flight read on pipeline flush without corrupting burst accounting.
// PARAMETERS
//  ADDR_W   32   byte address width
//  LINE_W   256  cacheline width in bits
//  BEAT_W   64   memory beat width; BEATS = LINE_W/BEAT_W (4), OFS = log2(LINE_W/8) (5)
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset: synchronous, active-high
//  cla_addr     in   ADDR_W  request address (low OFS bits ignored)
//  cla_read     in   1       line read request, held until cla_resp
//  cla_write    in   1       line write request, held until cla_resp
//  cla_wdata    in   LINE_W  write line, valid while cla_write high
//  cla_rdata    out  LINE_W  assembled read line, valid with cla_resp
//  cla_raddr    out  ADDR_W  line-aligned address of cla_rdata/response
//  cla_resp     out  1       one-cycle completion pulse (read or write)
//  discard      in   1       flush: drop response of current read
//  bmem_addr    out  ADDR_W  line-aligned burst address
//  bmem_read    out  1       read command, accepted when bmem_ready
//  bmem_write   out  1       write beat valid, accepted when bmem_ready
//  bmem_wdata   out  BEAT_W  write beat
//  bmem_ready   in   1       memory can accept command/beat this cycle
//  bmem_raddr   in   ADDR_W  address tag of returning read beats
//  bmem_rdata   in   BEAT_W  read beat
//  bmem_rvalid  in   1       read beat valid
// BEHAVIOUR
//  Reset: all outputs 0 (cla_rdata, cla_raddr, bmem_addr, bmem_wdata zeroed); state IDLE; beat cnt 0; drop flag 0.
//  States: IDLE, RD_CMD, RD_BEATS, WR_BEATS, RESP.
//  IDLE: cla_read -> latch {addr[ADDR_W-1:OFS],OFS'b0}, RD_CMD; else cla_write -> latch addr+wdata, WR_BEATS.
//   Both high: read wins. Request inputs sampled only at accept; later changes ignored until RESP.
//  RD_CMD: bmem_read=1, bmem_addr=latched; on bmem_ready -> RD_BEATS, cnt=0.
//  RD_BEATS: each bmem_rvalid stores beat cnt into cla_rdata[cnt*BEAT_W +: BEAT_W], cnt++.
//   Beats are in ascending order (beat 0 = bits [63:0]); cla_raddr <= bmem_raddr on beat 0.
//   After beat BEATS-1: drop flag clear -> RESP; drop flag set -> IDLE, no cla_resp, flag cleared.
//  WR_BEATS: bmem_write=1, bmem_addr held, bmem_wdata=line beat cnt; cnt++ on bmem_ready.
//   Ready low stalls with beat unchanged. After beat BEATS-1 accepted -> RESP; cla_raddr=latched addr.
//  RESP: cla_resp=1 exactly one cycle, cla_rdata/cla_raddr stable; -> IDLE. New request accepted next cycle at earliest.
//  Latency: read = 1 (cmd) + mem latency + BEATS + 1; write = BEATS (ready high) + 1.
//  discard: in RD_CMD/RD_BEATS sets drop flag; the read burst still completes (cmd issued, all beats consumed).
//   In RD_CMD an already-presented command is still issued, since the memory cannot cancel it.
//   In IDLE/WR_BEATS/RESP discard has no effect; writes always complete and respond.
//   discard same cycle as final beat: response dropped.
//  bmem_rvalid outside RD_BEATS: ignored, no state change.
//  cnt width clog2(BEATS); wrap only via state exit, never mid-burst.
//  rst mid-burst: immediate IDLE, outputs zeroed, in-flight beats afterwards ignored per above.
// TESTING
//  Read 0x0000_1234, ready=1, 4 beats A0..A3 after 10 cycles -> bmem_addr 0x1220, cla_rdata={A3,A2,A1,A0}, cla_raddr 0x1220, one resp pulse.
//  Write 0x8040 line W, ready toggles 1,0,1,1,0,1 -> 4 write beats W[63:0]..W[255:192] in order, beat held when ready=0, resp after 4th accept.
//  Read, discard pulsed during beat 2 -> all 4 beats consumed, no cla_resp, next read returns correct line with resp.
//  cla_read and cla_write both high in IDLE -> read burst issued, no bmem_write.
//  rst asserted after beat 1 of read -> outputs 0 next cycle; leftover rvalid beats ignored; subsequent read correct.
//  Back-to-back: request held high after resp -> exactly one resp per transaction, second command not issued before IDLE.

Source files
------------

// File: rtl/cacheline_adapter_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adapter_if
// Brief    : Cacheline request port plus banked-memory burst port bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface cacheline_adapter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic [ADDR_W-1:0] cla_addr;
    logic              cla_read;
    logic              cla_write;
    logic [LINE_W-1:0] cla_wdata;
    logic [LINE_W-1:0] cla_rdata;
    logic [ADDR_W-1:0] cla_raddr;
    logic              cla_resp;
    logic              discard;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    // Adapter side: responds on the cacheline port, drives the memory port.
    modport slave (
        input  cla_addr, cla_read, cla_write, cla_wdata, discard,
        output cla_rdata, cla_raddr, cla_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );

    modport master (
        output cla_addr, cla_read, cla_write, cla_wdata, discard,
        input  cla_rdata, cla_raddr, cla_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adapter
// Brief    : Splits 256-bit line reads/writes into 64-bit memory bursts.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_adapter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cacheline_adapter_if.slave  bus
);
    localparam int c_BEATS = LINE_W / BEAT_W;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);
    localparam logic [ADDR_W-1:0]  c_ALIGN_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_RD_CMD   = 3'd1;
    localparam logic [2:0] c_ST_RD_BEATS = 3'd2;
    localparam logic [2:0] c_ST_WR_BEATS = 3'd3;
    localparam logic [2:0] c_ST_RESP     = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;
    logic               drop_q,  drop_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [LINE_W-1:0]  rdata_q, rdata_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [BEAT_W-1:0]  w_wbeat;
    logic               w_drop_now;

    // A discard arriving on the final beat still suppresses the response.
    assign w_drop_now = drop_q | bus.discard;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rdata_d = rdata_q;
        raddr_d = raddr_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.cla_read) begin
                    addr_d  = bus.cla_addr & c_ALIGN_MASK;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    state_d = c_ST_RD_CMD;
                end else if (bus.cla_write) begin
                    addr_d  = bus.cla_addr & c_ALIGN_MASK;
                    wline_d = bus.cla_wdata;
                    cnt_d   = '0;
                    state_d = c_ST_WR_BEATS;
                end
            end
            c_ST_RD_CMD: begin
                // The command cannot be withdrawn once presented; only remember the flush.
                drop_d = w_drop_now;
                if (bus.bmem_ready) begin
                    cnt_d   = '0;
                    state_d = c_ST_RD_BEATS;
                end
            end
            c_ST_RD_BEATS: begin
                drop_d = w_drop_now;
                if (bus.bmem_rvalid) begin
                    for (int b = 0; b < c_BEATS; b++) begin
                        if (cnt_q == c_CNT_W'(b)) begin
                            rdata_d[b*BEAT_W +: BEAT_W] = bus.bmem_rdata;
                        end
                    end
                    if (cnt_q == '0) begin
                        raddr_d = bus.bmem_raddr;
                    end
                    if (cnt_q == c_LAST) begin
                        cnt_d   = '0;
                        drop_d  = 1'b0;
                        state_d = w_drop_now ? c_ST_IDLE : c_ST_RESP;
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
            end
            c_ST_WR_BEATS: begin
                if (bus.bmem_ready) begin
                    if (cnt_q == c_LAST) begin
                        cnt_d   = '0;
                        raddr_d = addr_q;
                        state_d = c_ST_RESP;
                    end else begin
                        cnt_d = cnt_q + c_CNT_W'(1);
                    end
                end
            end
            c_ST_RESP: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_wbeat = '0;
        for (int b = 0; b < c_BEATS; b++) begin
            if (cnt_q == c_CNT_W'(b)) begin
                w_wbeat = wline_q[b*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rdata_q <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rdata_q <= rdata_d;
            raddr_q <= raddr_d;
        end
    end

    assign bus.bmem_read  = (state_q == c_ST_RD_CMD);
    assign bus.bmem_write = (state_q == c_ST_WR_BEATS);
    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_wdata = w_wbeat;
    assign bus.cla_resp   = (state_q == c_ST_RESP);
    assign bus.cla_rdata  = rdata_q;
    assign bus.cla_raddr  = raddr_q;
endmodule
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_adapter
// Brief    : Self-checking bench: vector table, corner sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cacheline_adapter_if u_bus ();

    cacheline_adapter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus)
    );

    typedef struct {
        logic         wr;
        logic         both;
        logic [31:0]  addr;
        logic [255:0] line;
        int           lat;
        int           disc_at;
        int           rpct;
        logic [7:0]   rpat;
        int           rplen;
        int           exp_resp;
        logic [31:0]  exp_raddr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] all_outs();
        return {u_bus.cla_rdata, u_bus.cla_raddr, u_bus.cla_resp, u_bus.bmem_addr,
                u_bus.bmem_read, u_bus.bmem_write, u_bus.bmem_wdata};
    endfunction

    // One cacheline transaction with a behavioural memory on the burst side.
    // A read is expected to be dropped when discard is raised anywhere from the
    // first cycle its command is visible until its last beat is presented.
    task automatic run_txn(input logic wr, input logic both, input logic [31:0] addr,
                           input logic [255:0] line, input int lat, input int disc_at,
                           input int rpct, input logic [7:0] rpat, input int rplen,
                           input bit rnd, input int exp_resp, input logic [31:0] exp_raddr,
                           input bit hold);
        logic [255:0] wr_line, got_d;
        logic [31:0]  got_a;
        logic [63:0]  held;
        bit  stalled, acc, win, dropped, rd_seen, wr_seen, done, disc, beat_now_v;
        int  cmd_cnt, resp_cnt, wbeats, sent, beat_t, ridx, cyc, post, bad_addr, bad_hold, beat_now, exp_r;
        wr_line = '0; got_d = '0; got_a = '0; held = '0;
        stalled = 0; acc = 0; dropped = 0; rd_seen = 0; wr_seen = 0; done = 0;
        cmd_cnt = 0; resp_cnt = 0; wbeats = 0; sent = 0; beat_t = 0; ridx = 0;
        cyc = 0; post = 0; bad_addr = 0; bad_hold = 0; beat_now = -1;
        @(negedge clk);
        u_bus.cla_addr  = addr;
        u_bus.cla_read  = !wr || both;
        u_bus.cla_write = wr || both;
        u_bus.cla_wdata = line;
        while (!done) begin
            // Sample what the adapter presents this cycle.
            if (u_bus.cla_resp) begin
                resp_cnt++;
                got_d = u_bus.cla_rdata;
                got_a = u_bus.cla_raddr;
                if (!hold) begin
                    u_bus.cla_read  = 1'b0;
                    u_bus.cla_write = 1'b0;
                end
            end
            if (hold && resp_cnt > 0) break;
            if (u_bus.bmem_read) begin
                rd_seen = 1;
                if (u_bus.bmem_addr !== exp_raddr) bad_addr++;
            end
            if (u_bus.bmem_write) begin
                wr_seen = 1;
                if (u_bus.bmem_addr !== exp_raddr) bad_addr++;
                if (stalled && u_bus.bmem_wdata !== held) bad_hold++;
            end
            // Drive memory-side inputs for the coming edge.
            if (rplen > 0) begin
                if (u_bus.bmem_write && ridx < rplen) begin
                    u_bus.bmem_ready = rpat[ridx];
                    ridx++;
                end else begin
                    u_bus.bmem_ready = 1'b1;
                end
            end else begin
                u_bus.bmem_ready = ($urandom_range(99) < rpct);
            end
            if (u_bus.bmem_write) begin
                if (u_bus.bmem_ready) begin
                    if (wbeats < 4) wr_line[wbeats*64 +: 64] = u_bus.bmem_wdata;
                    wbeats++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = u_bus.bmem_wdata;
                end
            end
            if (u_bus.bmem_read && u_bus.bmem_ready) begin
                cmd_cnt++;
                if (!acc) begin
                    acc = 1;
                    beat_t = cyc + lat;
                end
            end
            win = !wr && rd_seen && sent < 4;
            beat_now_v = 0;
            if (acc && sent < 4 && cyc >= beat_t && (!rnd || $urandom_range(3) != 0)) begin
                u_bus.bmem_rvalid = 1'b1;
                u_bus.bmem_rdata  = line[sent*64 +: 64];
                u_bus.bmem_raddr  = exp_raddr;
                beat_now = sent;
                beat_now_v = 1;
                sent++;
            end else begin
                u_bus.bmem_rvalid = rnd && (!acc || sent == 4) && ($urandom_range(3) == 0);
                u_bus.bmem_rdata  = {$urandom, $urandom};
                u_bus.bmem_raddr  = $urandom;
            end
            disc = 0;
            if (disc_at >= 0) disc = wr ? (cyc == disc_at) : (beat_now_v && beat_now == disc_at);
            if (rnd && (wr || win) && $urandom_range(9) == 0) disc = 1;
            u_bus.discard = disc;
            if (disc && win) begin
                dropped = 1;
                u_bus.cla_read  = 1'b0;
                u_bus.cla_write = 1'b0;
            end
            if (wr ? (resp_cnt > 0) : (sent == 4 && (resp_cnt > 0 || dropped))) post++;
            if (post > 4) done = 1;
            cyc++;
            if (cyc > 400) begin
                checks++;
                failures++;
                $display("FAIL txn_timeout: addr %0h wr %0d got %0d resp expected completion", addr, wr, resp_cnt);
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        u_bus.bmem_ready  = 1'b0;
        u_bus.bmem_rvalid = 1'b0;
        u_bus.discard     = 1'b0;
        if (!hold) begin
            u_bus.cla_read  = 1'b0;
            u_bus.cla_write = 1'b0;
        end
        exp_r = (exp_resp >= 0) ? exp_resp : ((wr || !dropped) ? 1 : 0);
        chk("resp_count", resp_cnt, exp_r);
        chk("bmem_addr_aligned", bad_addr, 0);
        if (wr) begin
            chk("write_beats", wbeats, 4);
            chk("write_line", wr_line, line);
            chk("write_no_read_cmd", rd_seen, 0);
            chk("write_hold_stall", bad_hold, 0);
            if (exp_r == 1) chk("write_raddr", got_a, exp_raddr);
        end else begin
            chk("read_cmd_count", cmd_cnt, 1);
            chk("read_no_write", wr_seen, 0);
            if (exp_r == 1) begin
                chk("read_line", got_d, line);
                chk("read_raddr", got_a, exp_raddr);
            end
        end
    endtask

    initial begin
        logic [31:0]  ra;
        logic [255:0] rl;
        logic         rw;
        bit           stray;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234,
                    {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                     64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000},
                    10, -1, 100, 8'h00, 0, 1, 32'h0000_1220};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_8040,
                    {64'hD3D3_0000_1111_0003, 64'hD2D2_0000_1111_0002,
                     64'hD1D1_0000_1111_0001, 64'hD0D0_0000_1111_0000},
                    0, -1, 100, 8'h2D, 6, 1, 32'h0000_8040};
        vecs[2] = '{1'b0, 1'b0, 32'h0004_0007, {4{64'hBAD0_BAD0_BAD0_BAD0}},
                    3, 2, 100, 8'h00, 0, 0, 32'h0004_0000};
        vecs[3] = '{1'b0, 1'b0, 32'h0004_0007,
                    {64'h0C0C_0000_0000_0033, 64'h0C0C_0000_0000_0022,
                     64'h0C0C_0000_0000_0011, 64'h0C0C_0000_0000_0000},
                    2, -1, 100, 8'h00, 0, 1, 32'h0004_0000};
        vecs[4] = '{1'b0, 1'b1, 32'hDEAD_BEEF,
                    {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                     64'h5555_AAAA_5555_AAAA, 64'hFFFF_0000_FFFF_0000},
                    1, -1, 100, 8'h00, 0, 1, 32'hDEAD_BEE0};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFF,
                    {64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666,
                     64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444},
                    0, 1, 100, 8'h00, 0, 1, 32'hFFFF_FFE0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0100, {4{64'h0123_4567_89AB_CDEF}},
                    1, 3, 100, 8'h00, 0, 0, 32'h0000_0100};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0120,
                    {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                     64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0},
                    1, -1, 50, 8'h00, 0, 1, 32'h0000_0120};

        u_bus.cla_addr = '0; u_bus.cla_read = 1'b0; u_bus.cla_write = 1'b0;
        u_bus.cla_wdata = '0; u_bus.discard = 1'b0; u_bus.bmem_ready = 1'b0;
        u_bus.bmem_raddr = '0; u_bus.bmem_rdata = '0; u_bus.bmem_rvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", all_outs(), '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs_zero", all_outs(), '0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].line, vecs[i].lat,
                    vecs[i].disc_at, vecs[i].rpct, vecs[i].rpat, vecs[i].rplen, 1'b0,
                    vecs[i].exp_resp, vecs[i].exp_raddr, 1'b0);
        end

        // Back-to-back: request stays high across the response.
        run_txn(1'b0, 1'b0, 32'h0000_2468, {4{64'h2468_2468_0000_0001}}, 2, -1, 100,
                8'h00, 0, 1'b0, 1, 32'h0000_2460, 1'b1);
        @(negedge clk);
        chk("b2b_idle_gap", {u_bus.bmem_read, u_bus.cla_resp}, 2'b00);
        @(negedge clk);
        chk("b2b_second_cmd", {u_bus.bmem_read, u_bus.cla_resp}, 2'b10);
        run_txn(1'b0, 1'b0, 32'h0000_2468, {4{64'h2468_2468_0000_0002}}, 3, -1, 100,
                8'h00, 0, 1'b0, 1, 32'h0000_2460, 1'b0);

        // Reset after two read beats.
        @(negedge clk);
        u_bus.cla_addr = 32'h0000_5A5F; u_bus.cla_read = 1'b1; u_bus.bmem_ready = 1'b1;
        @(negedge clk);
        chk("rst_seq_cmd", u_bus.bmem_read, 1'b1);
        u_bus.cla_read = 1'b0;
        @(negedge clk);
        u_bus.bmem_rvalid = 1'b1; u_bus.bmem_raddr = 32'h0000_5A40;
        u_bus.bmem_rdata = 64'h1111_1111_1111_1111;
        @(negedge clk);
        u_bus.bmem_rdata = 64'h2222_2222_2222_2222;
        @(negedge clk);
        u_bus.bmem_rvalid = 1'b0;
        chk("rst_seq_partial", {u_bus.cla_raddr, u_bus.cla_rdata[127:0]},
            {32'h0000_5A40, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_burst_zero", all_outs(), '0);
        u_bus.bmem_rvalid = 1'b1; u_bus.bmem_rdata = 64'h3333_3333_3333_3333;
        @(negedge clk);
        u_bus.bmem_rdata = 64'h4444_4444_4444_4444;
        @(negedge clk);
        u_bus.bmem_rvalid = 1'b0; u_bus.bmem_ready = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            stray = stray | u_bus.cla_resp | u_bus.bmem_read | u_bus.bmem_write;
        end
        chk("rst_leftover_ignored", stray, 1'b0);
        chk("rst_leftover_rdata", u_bus.cla_rdata, '0);
        run_txn(1'b0, 1'b0, 32'h0000_5A5F,
                {64'h5A5A_0000_0000_0004, 64'h5A5A_0000_0000_0003,
                 64'h5A5A_0000_0000_0002, 64'h5A5A_0000_0000_0001},
                4, -1, 100, 8'h00, 0, 1'b0, 1, 32'h0000_5A40, 1'b0);

        // Random traffic with stalls, beat gaps, stray beats and flushes.
        for (int n = 0; n < 40; n++) begin
            rw = $urandom_range(1);
            ra = $urandom;
            rl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_txn(rw, 1'b0, ra, rl, $urandom_range(6, 1), -1, $urandom_range(100, 30),
                    8'h00, 0, 1'b1, -1, ra & 32'hFFFF_FFE0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
